// File: rtl/nabp_filtered_line_buffer_if.sv
// Bundle between the filtered line buffer, the sinogram addresser/RAM and the consumer.
// master: the line buffer (drives fr_s_val, fr_next_angle, pe_data, pe_angle, pe_valid, done).
// slave: the surroundings (drive hs_kick, fr_angle, fr_has_next_angle, sg_data, pe_s_addr, pe_next_angle).
interface nabp_filtered_line_buffer_if #(
  parameter int S_WIDTH     = 3,
  parameter int DATA_WIDTH  = 16,
  parameter int ANGLE_WIDTH = 9
) ();
  logic                   hs_kick;
  logic [ANGLE_WIDTH-1:0] fr_angle;
  logic                   fr_has_next_angle;
  logic [S_WIDTH-1:0]     fr_s_val;
  logic                   fr_next_angle;
  logic [DATA_WIDTH-1:0]  sg_data;
  logic [S_WIDTH-1:0]     pe_s_addr;
  logic [DATA_WIDTH-1:0]  pe_data;
  logic [ANGLE_WIDTH-1:0] pe_angle;
  logic                   pe_valid;
  logic                   pe_next_angle;
  logic                   done;

  modport master (
    input  hs_kick, fr_angle, fr_has_next_angle, sg_data, pe_s_addr, pe_next_angle,
    output fr_s_val, fr_next_angle, pe_data, pe_angle, pe_valid, done
  );

  modport slave (
    output hs_kick, fr_angle, fr_has_next_angle, sg_data, pe_s_addr, pe_next_angle,
    input  fr_s_val, fr_next_angle, pe_data, pe_angle, pe_valid, done
  );
endinterface

// File: rtl/nabp_filtered_line_buffer.sv
// Double-buffered projection line store: fills one bank from the sinogram RAM while the consumer reads the other.
// Latency: pe_data one cycle after pe_s_addr; one line per LINE_SIZE+2 cycles with a ready consumer.
// Backpressure: waits in FULL with fr_next_angle low (stalling the addresser) while both banks hold unconsumed lines.
// Ports: clk, reset_n (synchronous, active-low); bus (master modport) carries the addresser handshake
//   (hs_kick, fr_angle, fr_has_next_angle, fr_s_val, fr_next_angle), RAM data (sg_data),
//   consumer side (pe_s_addr, pe_data, pe_angle, pe_valid, pe_next_angle) and the done pulse.
module nabp_filtered_line_buffer #(
  parameter int S_WIDTH     = 3,
  parameter int LINE_SIZE   = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int ANGLE_WIDTH = 9
) (
  input  logic clk,
  input  logic reset_n,
  nabp_filtered_line_buffer_if.master bus
);

  typedef enum logic [2:0] {IDLE, REQ, FILL, FULL, DRAIN} state_t;

  localparam logic [S_WIDTH-1:0] S_LAST = S_WIDTH'(LINE_SIZE - 1);

  state_t                 state, state_nxt;
  logic [S_WIDTH-1:0]     s_cnt;
  logic [S_WIDTH-1:0]     s_d1;
  logic                   wr_en_d1;
  logic                   fill_sel;
  logic [ANGLE_WIDTH-1:0] fill_angle;
  logic                   pe_valid_q;
  logic [ANGLE_WIDTH-1:0] pe_angle_q;
  logic [DATA_WIDTH-1:0]  pe_data_q;
  logic                   last_s;
  logic                   swap;

  logic [DATA_WIDTH-1:0]  bank [2][LINE_SIZE];

  assign last_s       = (s_cnt == S_LAST);
  assign bus.pe_valid = pe_valid_q;
  assign bus.pe_angle = pe_angle_q;
  assign bus.pe_data  = pe_data_q;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.hs_kick) state_nxt = REQ;
      REQ:     state_nxt = bus.fr_has_next_angle ? FILL : DRAIN;
      FILL:    if (last_s) state_nxt = FULL;
      FULL:    if (swap) state_nxt = REQ;
      DRAIN:   if (!pe_valid_q) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic. A release in the same cycle as the swap frees the read bank,
  // so the freshly filled line can take its place without a bubble.
  always_comb begin
    bus.fr_next_angle = (state == REQ);
    bus.fr_s_val      = (state == FILL) ? s_cnt : '0;
    bus.done          = (state == DRAIN) && !pe_valid_q;
    swap              = (state == FULL) && (!pe_valid_q || bus.pe_next_angle);
  end

  // Sweep counter, write pipeline, bank ownership and consumer-side state.
  // RAM data arrives one cycle after the address, so the write index and
  // enable are delayed by one cycle; the last write lands on the first FULL edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s_cnt      <= '0;
      s_d1       <= '0;
      wr_en_d1   <= 1'b0;
      fill_sel   <= 1'b0;
      fill_angle <= '0;
      pe_valid_q <= 1'b0;
      pe_angle_q <= '0;
      pe_data_q  <= '0;
    end else begin
      s_cnt    <= (state == FILL && !last_s) ? s_cnt + 1'b1 : '0;
      s_d1     <= s_cnt;
      wr_en_d1 <= (state == FILL);
      if (state == FILL && s_cnt == '0) fill_angle <= bus.fr_angle;
      if (swap) begin
        fill_sel   <= ~fill_sel;
        pe_angle_q <= fill_angle;
        pe_valid_q <= 1'b1;
      end else if (bus.pe_next_angle) begin
        pe_valid_q <= 1'b0;
      end
      pe_data_q <= bank[~fill_sel][bus.pe_s_addr];
    end
  end

  // Bank storage carries no reset; contents are meaningless until written.
  // fill_sel is sampled before any same-edge toggle, so the final write of a
  // line still goes to the bank that was being filled.
  always_ff @(posedge clk) begin
    if (wr_en_d1) bank[fill_sel][s_d1] <= bus.sg_data;
  end

endmodule

// File: doc/nabp_filtered_line_buffer.md
# nabp_filtered_line_buffer

Double-buffered line store between the sinogram RAM and the processing swappable. It drives the sinogram addresser's `fr_s_val`/`fr_next_angle` inputs and sweeps one projection line per angle out of the sinogram RAM into a fill bank. When the consumer releases the other bank, the two banks swap, and the consumer reads the new line by s index. Filling of angle n+1 overlaps processing of angle n; the block stalls the addresser whenever both banks hold unconsumed lines.

## Interface

Parameters:
- `S_WIDTH`, `kSLength`: width of an s index.
- `LINE_SIZE`, `projection_line_size`: samples per projection line. Must satisfy `LINE_SIZE` ≤ 2^`S_WIDTH`.
- `DATA_WIDTH`, `kFilteredDataLength`: sample width.
- `ANGLE_WIDTH`, `kAngleLength`: angle tag width.

Ports:
- `clk`  in  1  clock.
- `reset_n`  in  1  reset.
- `hs_kick`  in  1  start pulse. Driven at the same time as the addresser's `hs_kick`.
- `fr_angle`  in  `ANGLE_WIDTH`  current angle from the addresser.
- `fr_has_next_angle`  in  1  from the addresser.
- `fr_s_val`  out  `S_WIDTH`  s offset to the addresser. The addresser forms `sg_addr` from it combinationally.
- `fr_next_angle`  out  1  one-cycle request to the addresser.
- `sg_data`  in  `DATA_WIDTH`  sinogram RAM read data. Valid 1 cycle after `sg_addr`.
- `pe_s_addr`  in  `S_WIDTH`  consumer read index.
- `pe_data`  out  `DATA_WIDTH`  read-bank sample. Registered, 1-cycle latency.
- `pe_angle`  out  `ANGLE_WIDTH`  angle tag of the read bank.
- `pe_valid`  out  1  read bank holds an unconsumed line.
- `pe_next_angle`  in  1  one-cycle pulse: consumer has finished with the read bank.
- `done`  out  1  one-cycle pulse after the last line has been released.

Reset: `reset_n`, synchronous, active-low; clock `clk`.

## Operation

Internal storage:
- Two banks of `LINE_SIZE` × `DATA_WIDTH`.
- `fill_sel` selects the fill bank; the read bank is `!fill_sel`.
- `fill_angle` holds the tag of the line being filled.

State machine:
- IDLE
  - Outputs 0. `hs_kick` → REQ.
  - `hs_kick` in any other state is ignored.
- REQ (1 cycle)
  - `fr_next_angle`=1.
  - If `fr_has_next_angle` → FILL, else → DRAIN.
  - In the first REQ after kick, the addresser only initialises (angle stays 0). In later REQs it advances `fr_angle` by one step at this edge.
- FILL (`LINE_SIZE` cycles)
  - `fr_s_val` = 0..`LINE_SIZE`-1, incrementing each cycle.
  - First FILL cycle: latch `fill_angle` ← `fr_angle`.
  - `sg_data` is written one cycle later to fill bank[`s_d1`], through a delayed write enable and `s_d1`.
  - After s = `LINE_SIZE`-1 → FULL.
- FULL
  - The final write lands at the first FULL edge.
  - Swap condition: `!pe_valid || pe_next_angle`. On swap:
    - `fill_sel` toggles.
    - `pe_angle` ← `fill_angle`.
    - `pe_valid` ← 1.
    - → REQ.
  - Otherwise hold; `fr_next_angle` stays low, which stalls the addresser.
- DRAIN
  - `pe_next_angle` clears `pe_valid`.
  - Once `pe_valid`=0: `done`=1 for one cycle, → IDLE.
  - The REQ that entered DRAIN is what triggers the addresser's `hs_done`.

Consumer side, outside a swap:
- `pe_next_angle` with `pe_valid`=1 clears `pe_valid`.
- `pe_next_angle` with `pe_valid`=0 is ignored.
- A swap and a release in the same cycle leave `pe_valid`=1 with the new tag.

`fr_s_val` is 0 outside FILL and never wraps.

## Timing

- Reset values: state IDLE, `fr_next_angle`=0, `fr_s_val`=0, `pe_valid`=0, `pe_angle`=0, `pe_data`=0, `done`=0, `fill_sel`=0.
- Reset mid-operation aborts immediately. Bank contents are don't-care.
- Kick at cycle 0 (in IDLE):
  - REQ at cycle 1.
  - FILL cycles 2..`LINE_SIZE`+1.
  - First FULL at `LINE_SIZE`+2.
  - `pe_valid` high from `LINE_SIZE`+3 if the read bank is free.
- Steady state with an always-ready consumer: one line per `LINE_SIZE`+2 cycles.
- `pe_data` = read bank[`pe_s_addr`] registered at the next edge.
- A read of the new bank is valid from the cycle `pe_valid` first rises.

## Test plan

- **Single kick, always-ready consumer.** Setup: `LINE_SIZE`=8, 4 angles (0..3 steps), `sg_data` = `sg_addr`. Required:
  - Four `pe_valid` lines, tagged 0,1,2,3.
  - Line k reads `pe_data` = 8k+s.
  - `done` one cycle after the final release.
  - The addresser raises `hs_done` exactly once.
- **Slow consumer.** Setup: release each line 30 cycles after `pe_valid` rises. Required:
  - The block sits in FULL with `fr_next_angle`=0.
  - No line is overwritten; all 32 samples are correct.
- **Simultaneous swap and release.** Setup: `pe_next_angle` in the first FULL cycle with `pe_valid`=1. Required:
  - `pe_valid` stays 1.
  - `pe_angle` steps to the next angle in one cycle.
- **Spurious release.** Stimulus: `pe_next_angle` while `pe_valid`=0, then `hs_kick` during FILL. Required: both are ignored, and the line sequence is unchanged.
- **Reset mid-FILL.** Stimulus: `reset_n`=0 at s=3 of angle 1. Required:
  - Next cycle all outputs are at reset values.
  - A re-kick then completes 4 correct lines.
- **Last-line drain.** Stimulus: hold the final release for 10 cycles. Required: `done` asserts exactly 1 cycle after the release and is not asserted before it.
